// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: one product or quotient bit per cycle,
// with divide-by-zero and signed-overflow cases resolved at acceptance.
module ex_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            mdu_req_i,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] mdu_a_i,
    input  logic [XLEN-1:0] mdu_b_i,
    input  logic            mdu_flush_i,
    output logic            mdu_ready_o,
    output logic            mdu_valid_o,
    output logic [XLEN-1:0] mdu_data_o
);
    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Operand decode at the request port.
    logic            accept, is_div, sgn_a, sgn_b, div_zero, div_ovf, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        accept   = mdu_req_i & ~mdu_flush_i & (state_q == S_IDLE);
        is_div   = mdu_op_i[2];
        sgn_a    = mdu_a_i[XLEN-1] & (is_div ? ~mdu_op_i[0] : (mdu_op_i != 3'd3));
        sgn_b    = mdu_b_i[XLEN-1] & (is_div ? ~mdu_op_i[0] : ~mdu_op_i[1]);
        a_mag    = sgn_a ? -mdu_a_i : mdu_a_i;
        b_mag    = sgn_b ? -mdu_b_i : mdu_b_i;
        div_zero = is_div & (mdu_b_i == '0);
        div_ovf  = is_div & ~mdu_op_i[0] & (mdu_a_i == INT_MIN) & (&mdu_b_i);
        fast     = div_zero | div_ovf;
        if (div_zero) begin
            fast_res = mdu_op_i[1] ? mdu_a_i : '1;
        end else begin
            fast_res = mdu_op_i[1] ? '0 : mdu_a_i;
        end
    end

    // One iteration step; hi holds the upper product half or the partial remainder,
    // lo the multiplier bits still to consume or the dividend/quotient shift register.
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic              div_neg;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opd_q};
        div_neg   = div_trial[XLEN];
        if (op_q[2]) begin
            hi_step = div_neg ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ~div_neg};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {hi_step, lo_step};
        prod_s = neg_res_q ? -prod : prod;
        quo_s  = neg_res_q ? -lo_step : lo_step;
        rem_s  = neg_rem_q ? -hi_step : hi_step;
        case (op_q)
            3'd0:             calc_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: calc_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       calc_res = quo_s;
            default:          calc_res = rem_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opd_d     = opd_q;
        res_d     = res_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = mdu_op_i;
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    hi_d      = '0;
                    cnt_d     = '0;
                    lo_d      = is_div ? a_mag : b_mag;
                    opd_d     = is_div ? b_mag : a_mag;
                    if (fast) begin
                        res_d   = fast_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (mdu_flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = hi_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        res_d   = calc_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!mdu_flush_i) begin
                    data_d = res_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opd_q     <= '0;
            res_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opd_q     <= opd_d;
            res_q     <= res_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
        end
    end

    // A flush in DONE hides both the pulse and the new result; data_q keeps the old one.
    assign mdu_ready_o = (state_q == S_IDLE);
    assign mdu_valid_o = (state_q == S_DONE) & ~mdu_flush_i;
    assign mdu_data_o  = mdu_valid_o ? res_q : data_q;

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Iterative multiply/divide unit for the EX stage, alongside the single-cycle ALU. Implements the RV32M/RV64M operation set.
- Takes operands on a request/ready handshake and computes one bit per cycle.
- Returns a single-cycle valid pulse with a held result.
- The EX stage stalls on mdu_ready_o low.

Parameters:
- XLEN, 32, operand/result width; also the iteration count (must be power of two, >= 8).

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_n_i  input  1  synchronous active-low reset.
- mdu_req_i  input  1  start request; accepted when mdu_req_i & mdu_ready_o.
- mdu_op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- mdu_a_i  input  XLEN  rs1 operand (dividend / multiplicand).
- mdu_b_i  input  XLEN  rs2 operand (divisor / multiplier).
- mdu_flush_i  input  1  abort current operation (pipeline flush).
- mdu_ready_o  output  1  high in IDLE only.
- mdu_valid_o  output  1  one-cycle pulse, result valid.
- mdu_data_o  output  XLEN  result; held from valid pulse until next acceptance.

Behaviour:
- Reset (rst_n_i low at edge): state IDLE, mdu_ready_o=1, mdu_valid_o=0, mdu_data_o=0, all internal registers cleared.
  - Reset overrides flush and req.
  - Reset mid-operation aborts with no valid pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - On accept at edge T, latch op, operand signs, and operand magnitudes.
  - Signed operand: MUL/MULH/DIV/REM both operands; MULHSU rs1 only.
  - Next state CALC, except fast-path cases, which go directly to DONE.
- CALC:
  - XLEN iterations, counter 0..XLEN-1.
  - Multiply: shift-add over the 2*XLEN accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle; the remainder register is XLEN+1 bits for the trial subtract.
  - At counter == XLEN-1, go to DONE.
- DONE:
  - Apply sign correction: negate the product if the operand signs differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Register the result into mdu_data_o and pulse mdu_valid_o for exactly this cycle; next state IDLE.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Latency:
  - Normal: accept edge T, valid high in cycle T+XLEN+1; mdu_ready_o high again from T+XLEN+2.
  - Fast path: valid in cycle T+1.
  - Throughput: one op per XLEN+2 cycles.
- Fast paths (no CALC):
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend.
  - Signed overflow, DIV/REM with a = -2^(XLEN-1) and b = -1: quotient = a, remainder = 0.
  - MUL-family ops with either operand 0 are not fast-pathed; they take the full latency.
- mdu_ready_o is low in CALC and DONE. mdu_req_i is ignored there; the requester holds the request.
- Flush:
  - mdu_flush_i in CALC or DONE returns to IDLE at the next edge with no valid pulse; mdu_data_o is unchanged.
  - Flush in DONE suppresses the pulse, because valid is registered on the DONE entry edge and flush gates it combinationally: mdu_valid_o = done_q & ~mdu_flush_i.
  - Flush in IDLE blocks acceptance in that cycle.
- Operands are sampled only at acceptance; input changes during CALC have no effect.

Test Plan:
- MUL / MULHU: a=0xFFFF_FFFF, b=0xFFFF_FFFF. MUL -> 0x0000_0001 and MULHU -> 0xFFFF_FFFE, each with valid exactly XLEN+1 (33) cycles after accept and ready low for 33 cycles.
- MULH / MULHSU: a=0xFFFF_FFFF (-1), b=0x0000_0002. MULH -> 0xFFFF_FFFF; MULHSU -> 0xFFFF_FFFF; MULHU -> 0x0000_0001.
- Signed division: a=-7 (0xFFFF_FFF9), b=2. DIV -> 0xFFFF_FFFD (-3); REM -> 0xFFFF_FFFF (-1); DIVU -> 0x7FFF_FFFC; REMU -> 1.
- Divide by zero and overflow:
  - DIV a=5, b=0 -> 0xFFFF_FFFF, valid one cycle after accept.
  - REM a=5, b=0 -> 5, valid one cycle after accept.
  - DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000, valid one cycle after accept.
  - REM a=0x8000_0000, b=0xFFFF_FFFF -> 0, valid one cycle after accept.
- Flush / reset mid-op:
  - Start DIVU 100/7; assert flush at CALC cycle 10 -> no valid, ready high next cycle, mdu_data_o keeps its prior value.
  - Immediate new DIVU 100/7 -> 14.
  - Repeat with rst_n_i low mid-CALC -> data 0, no pulse.
- Back-to-back and stalls:
  - Hold mdu_req_i high with changing operands during CALC -> only the first-sampled operands are used.
  - Second op accepted the cycle after the valid pulse.
  - Random 10k ops vs. a reference model, all eight ops, including XLEN=64.
